// File: rtl/risco5_uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package risco5_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // Width of a counter that must hold every value from 0 up to and including depth.
  function automatic int levelWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO with a combinational head output and an explicit fill counter.
module uart_tx_fifo
  import risco5_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [7:0]                   wdata,
  input  logic                         pop,
  output logic [7:0]                   rdata,
  output logic [levelWidth(DEPTH)-1:0] level,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = levelWidth(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic          doPush;
  logic          doPop;

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign rdata  = mem_q[rdPtr_q];
  assign level  = level_q;

  // Pointers wrap naturally because DEPTH is a power of two; the level moves only on a lone push or pop.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({doPush, doPop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is not reset: a zero level already marks every entry as invalid.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata;
  end

  // Pointer and level registers, cleared on reset so queued bytes are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed from a small byte FIFO through a valid/ready handshake.
module uart_tx_buffered
  import risco5_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BAUD_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT  = 3'(UART_DATA_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          fifoPop;
  logic [7:0]    fifoData;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          baudDone;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid_i & tx_ready_o),
    .wdata (tx_data_i),
    .pop   (fifoPop),
    .rdata (fifoData),
    .level (fifo_level_o),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign tx_ready_o = ~fifoFull;
  assign busy_o     = (state_q != IDLE) | ~fifoEmpty;
  assign tx_o       = tx_q;
  assign baudDone   = (baudCnt_q == '0);

  // Frame sequencer: tx_d always carries the line level belonging to the state being entered.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifoPop   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          shift_d   = fifoData;
          baudCnt_d = BAUD_LOAD;
          state_d   = START;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (baudDone) begin
          state_d   = DATA;
          bitIdx_d  = '0;
          baudCnt_d = BAUD_LOAD;
          tx_d      = shift_q[0];
        end else begin
          baudCnt_d = baudCnt_q - CW'(1);
        end
      end
      DATA: begin
        if (baudDone) begin
          baudCnt_d = BAUD_LOAD;
          if (bitIdx_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d  = shift_q >> 1;
            bitIdx_d = bitIdx_q + 3'd1;
            tx_d     = shift_q[1];
          end
        end else begin
          baudCnt_d = baudCnt_q - CW'(1);
        end
      end
      STOP: begin
        if (baudDone) begin
          if (!fifoEmpty) begin
            fifoPop   = 1'b1;
            shift_d   = fifoData;
            baudCnt_d = BAUD_LOAD;
            state_d   = START;
            tx_d      = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baudCnt_d = baudCnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Sequencer registers; reset forces the line high at once, truncating any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: three instances (4, 2 and 5 clocks per bit) share clock and reset.
module tb_uart_tx_buffered;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  // 10 ns system clock
  always #5 clk = ~clk;

  logic [7:0] data4 = 8'h00, data2 = 8'h00, data5 = 8'h00;
  logic       valid4 = 1'b0, valid2 = 1'b0, valid5 = 1'b0;
  logic       ready4, ready2, ready5;
  logic       tx4, tx2, tx5;
  logic       busy4, busy2, busy5;
  logic [2:0] level4, level2, level5;

  int testsRun = 0;
  int failures = 0;
  int cycleCnt = 0;
  int frameErr [3] = '{0, 0, 0};

  logic [7:0] rxQ4 [$];
  logic [7:0] rxQ2 [$];
  logic [7:0] rxQ5 [$];
  int         rxStart4 [$];

  uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tx_data_i(data4), .tx_valid_i(valid4),
    .tx_ready_o(ready4), .tx_o(tx4), .busy_o(busy4), .fifo_level_o(level4));

  uart_tx_buffered #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data_i(data2), .tx_valid_i(valid2),
    .tx_ready_o(ready2), .tx_o(tx2), .busy_o(busy2), .fifo_level_o(level2));

  uart_tx_buffered #(.CLKS_PER_BIT(5), .FIFO_DEPTH(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .tx_data_i(data5), .tx_valid_i(valid5),
    .tx_ready_o(ready5), .tx_o(tx5), .busy_o(busy5), .fifo_level_o(level5));

  // Free-running cycle count used to timestamp frame starts
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Instance selectors: 0 = 4 clks/bit, 1 = 2 clks/bit, 2 = 5 clks/bit
  function automatic logic lineOf(input int which);
    case (which)
      0:       return tx4;
      1:       return tx2;
      default: return tx5;
    endcase
  endfunction

  function automatic logic readyOf(input int which);
    case (which)
      0:       return ready4;
      1:       return ready2;
      default: return ready5;
    endcase
  endfunction

  function automatic logic busyOf(input int which);
    case (which)
      0:       return busy4;
      1:       return busy2;
      default: return busy5;
    endcase
  endfunction

  function automatic int rxSize(input int which);
    case (which)
      0:       return rxQ4.size();
      1:       return rxQ2.size();
      default: return rxQ5.size();
    endcase
  endfunction

  function automatic logic [7:0] rxAt(input int which, input int i);
    case (which)
      0:       return rxQ4[i];
      1:       return rxQ2[i];
      default: return rxQ5[i];
    endcase
  endfunction

  task automatic rxClear(input int which);
    case (which)
      0:       begin rxQ4.delete(); rxStart4.delete(); end
      1:       rxQ2.delete();
      default: rxQ5.delete();
    endcase
    frameErr[which] = 0;
  endtask

  task automatic driveIn(input int which, input logic v, input logic [7:0] d);
    case (which)
      0:       begin valid4 = v; data4 = d; end
      1:       begin valid2 = v; data2 = d; end
      default: begin valid5 = v; data5 = d; end
    endcase
  endtask

  // Reference receiver: samples every falling clock edge, reads each bit in the middle of its bit time
  task automatic decodeLine(input int which, input int cpb);
    logic [7:0] b;
    logic       aborted;
    int         startCyc;
    forever begin
      @(negedge clk);
      if (!rst_n || lineOf(which) !== 1'b0) continue;
      startCyc = cycleCnt;
      b        = 8'h00;
      aborted  = 1'b0;
      for (int idx = 1; idx <= 9 * cpb + cpb / 2; idx++) begin
        @(negedge clk);
        if (!rst_n) begin
          aborted = 1'b1;
          break;
        end
        if (idx == cpb / 2 && lineOf(which) !== 1'b0) begin
          frameErr[which]++;
          aborted = 1'b1;
          break;
        end
        if (idx >= cpb && idx < 9 * cpb && (idx % cpb) == cpb / 2)
          b[(idx / cpb) - 1] = lineOf(which);
      end
      if (!aborted) begin
        if (lineOf(which) !== 1'b1) frameErr[which]++;
        case (which)
          0:       begin rxQ4.push_back(b); rxStart4.push_back(startCyc); end
          1:       rxQ2.push_back(b);
          default: rxQ5.push_back(b);
        endcase
      end
    end
  endtask

  // Present a byte from a falling edge and return just after the rising edge that takes it
  task automatic applyStimulus(input int which, input logic [7:0] b, output int waited);
    @(negedge clk);
    driveIn(which, 1'b1, b);
    waited = 0;
    while (!readyOf(which) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
  endtask

  task automatic releaseInputs(input int which);
    @(negedge clk);
    driveIn(which, 1'b0, 8'h00);
  endtask

  task automatic waitIdle(input int which, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (busyOf(which) && cycles < 2000);
  endtask

  // Asynchronous reset must take effect before any clock edge arrives
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    testsRun++; if (tx4 !== 1'b1)      begin failures++; $display("[TB] FAIL reset_tx got %b want 1", tx4); end
    testsRun++; if (ready4 !== 1'b1)   begin failures++; $display("[TB] FAIL reset_ready got %b want 1", ready4); end
    testsRun++; if (busy4 !== 1'b0)    begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy4); end
    testsRun++; if (level4 !== 3'd0)   begin failures++; $display("[TB] FAIL reset_level got %0d want 0", level4); end
    testsRun++; if (tx2 !== 1'b1 || tx5 !== 1'b1)
      begin failures++; $display("[TB] FAIL reset_tx_others got %b%b want 11", tx2, tx5); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // One 0xA5 frame checked cycle by cycle: start, LSB-first data, stop
  task automatic test_single_frame();
    logic [9:0] fr;
    int w;
    fr = {1'b1, 8'hA5, 1'b0};
    rxClear(0);
    applyStimulus(0, 8'hA5, w);
    #1;
    testsRun++; if (level4 !== 3'd1 || tx4 !== 1'b1 || busy4 !== 1'b1)
      begin failures++; $display("[TB] FAIL single_accept got level=%0d tx=%b busy=%b want 1 1 1", level4, tx4, busy4); end
    releaseInputs(0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      testsRun++; if (tx4 !== fr[k / 4] || busy4 !== 1'b1)
        begin failures++; $display("[TB] FAIL single_bit cycle %0d got tx=%b busy=%b want tx=%b busy=1", k, tx4, busy4, fr[k / 4]); end
      if (k == 0) begin
        testsRun++; if (level4 !== 3'd0)
          begin failures++; $display("[TB] FAIL single_pop got level=%0d want 0", level4); end
      end
    end
    @(posedge clk); #1;
    testsRun++; if (busy4 !== 1'b0 || tx4 !== 1'b1)
      begin failures++; $display("[TB] FAIL single_end got busy=%b tx=%b want 0 1", busy4, tx4); end
    testsRun++; if (rxSize(0) !== 1 || rxAt(0, 0) !== 8'hA5)
      begin failures++; $display("[TB] FAIL single_decode got n=%0d want 1 byte A5", rxSize(0)); end
  endtask

  // Three queued bytes must leave as gapless 40-cycle frames
  task automatic test_back_to_back();
    logic [7:0] exp [3];
    int w, cyc;
    exp = '{8'h55, 8'h0F, 8'hFF};
    rxClear(0);
    for (int i = 0; i < 3; i++) applyStimulus(0, exp[i], w);
    releaseInputs(0);
    waitIdle(0, cyc);
    testsRun++; if (cyc >= 2000) begin failures++; $display("[TB] FAIL b2b_timeout got %0d cycles want <2000", cyc); end
    testsRun++; if (rxSize(0) !== 3) begin failures++; $display("[TB] FAIL b2b_count got %0d want 3", rxSize(0)); end
    for (int i = 0; i < 3 && i < rxSize(0); i++) begin
      testsRun++; if (rxAt(0, i) !== exp[i])
        begin failures++; $display("[TB] FAIL b2b_byte%0d got %h want %h", i, rxAt(0, i), exp[i]); end
    end
    for (int i = 1; i < 3 && i < rxStart4.size(); i++) begin
      testsRun++; if (rxStart4[i] - rxStart4[i - 1] !== 40)
        begin failures++; $display("[TB] FAIL b2b_spacing%0d got %0d want 40", i, rxStart4[i] - rxStart4[i - 1]); end
    end
    testsRun++; if (frameErr[0] !== 0) begin failures++; $display("[TB] FAIL b2b_framing got %0d want 0", frameErr[0]); end
  endtask

  // Valid held high for six bytes: ready must drop at level 4 and the sixth byte wait for a frame to finish
  task automatic test_full_backpressure();
    logic [7:0] exp [6];
    int w, cyc;
    exp = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    rxClear(0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, exp[i], w);
      if (i < 5) begin
        testsRun++; if (w !== 0) begin failures++; $display("[TB] FAIL bp_nowait%0d got %0d want 0", i, w); end
      end else begin
        testsRun++; if (w < 30 || w >= 500)
          begin failures++; $display("[TB] FAIL bp_stall got %0d cycles want 30..499", w); end
      end
      if (i == 4) begin
        @(negedge clk);
        testsRun++; if (level4 !== 3'd4 || ready4 !== 1'b0)
          begin failures++; $display("[TB] FAIL bp_full got level=%0d ready=%b want 4 0", level4, ready4); end
      end
    end
    releaseInputs(0);
    waitIdle(0, cyc);
    testsRun++; if (rxSize(0) !== 6) begin failures++; $display("[TB] FAIL bp_count got %0d want 6", rxSize(0)); end
    for (int i = 0; i < 6 && i < rxSize(0); i++) begin
      testsRun++; if (rxAt(0, i) !== exp[i])
        begin failures++; $display("[TB] FAIL bp_byte%0d got %h want %h", i, rxAt(0, i), exp[i]); end
    end
  endtask

  // Data wiggled while the FIFO is full must never be taken
  task automatic test_ignore_when_full();
    logic [7:0] exp [5];
    int w, cyc;
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rxClear(0);
    for (int i = 0; i < 5; i++) applyStimulus(0, exp[i], w);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      driveIn(0, 1'b1, 8'hE0 + 8'(j));
      testsRun++; if (level4 !== 3'd4 || ready4 !== 1'b0)
        begin failures++; $display("[TB] FAIL ignore_level%0d got level=%0d ready=%b want 4 0", j, level4, ready4); end
    end
    releaseInputs(0);
    waitIdle(0, cyc);
    testsRun++; if (rxSize(0) !== 5) begin failures++; $display("[TB] FAIL ignore_count got %0d want 5", rxSize(0)); end
    for (int i = 0; i < 5 && i < rxSize(0); i++) begin
      testsRun++; if (rxAt(0, i) !== exp[i])
        begin failures++; $display("[TB] FAIL ignore_byte%0d got %h want %h", i, rxAt(0, i), exp[i]); end
    end
  endtask

  // Reset during data bit 3 of 0x3C with two bytes queued, then the line must stay idle
  task automatic test_reset_mid_frame();
    int w;
    logic idleOk;
    rxClear(0);
    applyStimulus(0, 8'h3C, w);
    applyStimulus(0, 8'hA1, w);
    applyStimulus(0, 8'hB2, w);
    releaseInputs(0);
    repeat (8) @(posedge clk);
    #1;
    testsRun++; if (tx4 !== 1'b0)
      begin failures++; $display("[TB] FAIL rstmid_bit1 got tx=%b want 0", tx4); end
    repeat (8) @(posedge clk);
    #1;
    testsRun++; if (busy4 !== 1'b1 || level4 !== 3'd2 || tx4 !== 1'b1)
      begin failures++; $display("[TB] FAIL rstmid_before got busy=%b level=%0d tx=%b want 1 2 1", busy4, level4, tx4); end
    rst_n = 1'b0;
    #1;
    testsRun++; if (tx4 !== 1'b1 || level4 !== 3'd0 || busy4 !== 1'b0 || ready4 !== 1'b1)
      begin failures++; $display("[TB] FAIL rstmid_after got tx=%b level=%0d busy=%b ready=%b want 1 0 0 1", tx4, level4, busy4, ready4); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idleOk = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx4 !== 1'b1 || busy4 !== 1'b0) idleOk = 1'b0;
    end
    testsRun++; if (idleOk !== 1'b1)
      begin failures++; $display("[TB] FAIL rstmid_idle got activity after release want idle line"); end
    testsRun++; if (rxSize(0) !== 0)
      begin failures++; $display("[TB] FAIL rstmid_rx got %0d bytes want 0", rxSize(0)); end
  endtask

  // Fixed bursts with gaps of differing lengths against the reference receiver
  task automatic test_random_bursts(input int which);
    int lens [6];
    int gaps [6];
    logic [7:0] exp [$];
    logic [7:0] b;
    int w, cyc, k;
    lens = '{1, 3, 2, 5, 1, 4};
    gaps = '{0, 7, 13, 2, 25, 0};
    rxClear(which);
    k = 0;
    for (int bi = 0; bi < 6; bi++) begin
      for (int j = 0; j < lens[bi]; j++) begin
        b = 8'(k * 73 + 29 + which * 5);
        applyStimulus(which, b, w);
        exp.push_back(b);
        k++;
        testsRun++; if (w >= 500)
          begin failures++; $display("[TB] FAIL burst%0d_accept byte %0d got timeout want accepted", which, k); end
      end
      releaseInputs(which);
      repeat (gaps[bi]) @(negedge clk);
    end
    waitIdle(which, cyc);
    testsRun++; if (rxSize(which) !== exp.size())
      begin failures++; $display("[TB] FAIL burst%0d_count got %0d want %0d", which, rxSize(which), exp.size()); end
    for (int i = 0; i < exp.size() && i < rxSize(which); i++) begin
      testsRun++; if (rxAt(which, i) !== exp[i])
        begin failures++; $display("[TB] FAIL burst%0d_byte%0d got %h want %h", which, i, rxAt(which, i), exp[i]); end
    end
    testsRun++; if (frameErr[which] !== 0)
      begin failures++; $display("[TB] FAIL burst%0d_framing got %0d want 0", which, frameErr[which]); end
  endtask

  // Receivers run for the whole simulation; scenarios run one after another
  initial begin
    fork
      decodeLine(0, 4);
      decodeLine(1, 2);
      decodeLine(2, 5);
    join_none
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_full_backpressure();
    test_ignore_when_full();
    test_reset_mid_frame();
    test_random_bursts(1);
    test_random_bursts(2);
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
